// File: rtl/coeff_decomposer_lanes_if.sv
// Handshake and data bundle for coeff_decomposer_lanes: upstream beat in, decomposed beat out.
// master = producer/consumer side (the stream environment), slave = the decomposer itself.
interface coeff_decomposer_lanes_if #(
  parameter int LANES   = 4,
  parameter int COEFF_W = 24,
  parameter int R1_W    = 10
);
  logic [2:0]               sec_lvl;
  logic                     mode;
  logic                     valid_i;
  logic                     ready_i;
  logic [LANES*COEFF_W-1:0] di;
  logic                     valid_o;
  logic                     ready_o;
  logic [LANES*R1_W-1:0]    doa;
  logic [LANES*COEFF_W-1:0] dob;

  modport master (
    output sec_lvl, mode, valid_i, di, ready_o,
    input  ready_i, valid_o, doa, dob
  );

  modport slave (
    input  sec_lvl, mode, valid_i, di, ready_o,
    output ready_i, valid_o, doa, dob
  );
endinterface

// File: rtl/coeff_decomposer_lanes.sv
// Multi-lane Dilithium Decompose / Power2Round splitter, three register stages with a global stall.
// S1 reduces mod q, S2 forms quotient/remainder, S3 applies centring, the q-1 corner and residue mapping.
module coeff_decomposer_lanes #(
  parameter int LANES   = 4,
  parameter int COEFF_W = 24,
  parameter int R1_W    = 10
) (
  input logic                  clk,
  input logic                  rst,
  coeff_decomposer_lanes_if.slave bus
);
  localparam int SW = COEFF_W + 2;
  localparam logic [COEFF_W-1:0] QV    = COEFF_W'(8380417);
  localparam logic [COEFF_W-1:0] G2_LO = COEFF_W'(95232);
  localparam logic [COEFF_W-1:0] G2_HI = COEFF_W'(261888);
  localparam logic [COEFF_W-1:0] A_LO  = COEFF_W'(190464);
  localparam logic [COEFF_W-1:0] A_HI  = COEFF_W'(523776);
  // Reciprocals rounded up at 2^48 scale: the error term stays below 2^43, so floor(r/a) is exact for all r < 2^24.
  localparam logic [31:0] M_LO = 32'(((64'd1 << 48) + 64'd190463) / 64'd190464);
  localparam logic [31:0] M_HI = 32'(((64'd1 << 48) + 64'd523775) / 64'd523776);
  localparam logic [R1_W-1:0] QMAX_LO = R1_W'(44);
  localparam logic [R1_W-1:0] QMAX_HI = R1_W'(16);
  localparam logic signed [SW-1:0] ONE_S = SW'(1);
  localparam logic signed [SW-1:0] QS    = $signed({2'b00, QV});

  logic en;
  logic s1_valid, s2_valid, s3_valid;
  logic s1_lo, s1_p2r, s2_lo, s2_p2r;

  assign en          = !s3_valid || bus.ready_o;
  assign bus.ready_i = en;
  assign bus.valid_o = s3_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_lo    <= 1'b0;
      s1_p2r   <= 1'b0;
      s2_lo    <= 1'b0;
      s2_p2r   <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.valid_i;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      s1_lo    <= (bus.sec_lvl == 3'b010);
      s1_p2r   <= bus.mode;
      s2_lo    <= s1_lo;
      s2_p2r   <= s1_p2r;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [COEFF_W-1:0]   din, red, s1_r;
    logic [COEFF_W-1:0]   a_c, rem_c, s2_rem, half, a3;
    logic [31:0]          m_c;
    logic [7:0]           qd;
    logic [R1_W-1:0]      quo_c, s2_quo, hi, r1_c, doa_r;
    logic signed [SW-1:0] r0s;
    logic [COEFF_W-1:0]   dob_c, dob_r;

    assign din = bus.di[k*COEFF_W +: COEFF_W];
    assign red = (din >= QV) ? din - QV : din;

    always_comb begin
      m_c = s1_lo ? M_LO : M_HI;
      a_c = s1_lo ? A_LO : A_HI;
      qd  = 8'((56'(s1_r) * 56'(m_c)) >> 48);
      if (s1_p2r) begin
        quo_c = R1_W'(s1_r >> 13);
        rem_c = COEFF_W'(s1_r[12:0]);
      end else begin
        quo_c = R1_W'(qd);
        rem_c = s1_r - COEFF_W'(qd) * a_c;
      end
    end

    // Centre the remainder into (-half, half]; r - r0 == q-1 only happens at the top quotient.
    always_comb begin
      half = s2_p2r ? COEFF_W'(4096) : (s2_lo ? G2_LO : G2_HI);
      a3   = s2_p2r ? COEFF_W'(8192) : (s2_lo ? A_LO : A_HI);
      r0s  = $signed({2'b00, s2_rem});
      hi   = s2_quo;
      if (s2_rem > half) begin
        r0s = r0s - $signed({2'b00, a3});
        hi  = s2_quo + R1_W'(1);
      end
      r1_c = hi;
      if (!s2_p2r && hi == (s2_lo ? QMAX_LO : QMAX_HI)) begin
        r1_c = '0;
        r0s  = r0s - ONE_S;
      end
      dob_c = COEFF_W'(r0s[SW-1] ? r0s + QS : r0s);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_r   <= '0;
        s2_quo <= '0;
        s2_rem <= '0;
        doa_r  <= '0;
        dob_r  <= '0;
      end else if (en) begin
        s1_r   <= red;
        s2_quo <= quo_c;
        s2_rem <= rem_c;
        doa_r  <= r1_c;
        dob_r  <= dob_c;
      end
    end

    assign bus.doa[k*R1_W +: R1_W]       = doa_r;
    assign bus.dob[k*COEFF_W +: COEFF_W] = dob_r;
  end
endmodule

// File: tb/tb_coeff_decomposer_lanes.sv
// Scoreboard bench for coeff_decomposer_lanes: a division-based reference model fills an expected queue
// on every accepted beat, and an independent monitor pops and compares on every output transfer.
module tb_coeff_decomposer_lanes;
  localparam int LANES   = 4;
  localparam int COEFF_W = 24;
  localparam int R1_W    = 10;
  localparam int Q       = 8380417;

  typedef struct {
    logic [LANES*R1_W-1:0]    doa;
    logic [LANES*COEFF_W-1:0] dob;
    int                       t_in;
    bit                       lat;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   passes;
  bit   lat_mode;
  exp_t sb[$];

  coeff_decomposer_lanes_if #(.LANES(LANES), .COEFF_W(COEFF_W), .R1_W(R1_W)) bus ();

  coeff_decomposer_lanes #(.LANES(LANES), .COEFF_W(COEFF_W), .R1_W(R1_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: straight from the Decompose / Power2Round definitions using / and %.
  function automatic void model(input logic [LANES*COEFF_W-1:0] d, input logic [2:0] s, input logic m,
                                output logic [LANES*R1_W-1:0] da, output logic [LANES*COEFF_W-1:0] db);
    int r, r0, r1, g, a;
    da = '0;
    db = '0;
    for (int k = 0; k < LANES; k++) begin
      r = int'(d[k*COEFF_W +: COEFF_W]);
      if (r >= Q) r = r - Q;
      if (m) begin
        r0 = r % 8192;
        if (r0 > 4096) r0 = r0 - 8192;
        r1 = (r - r0) / 8192;
      end else begin
        g  = (s == 3'b010) ? 95232 : 261888;
        a  = 2 * g;
        r0 = r % a;
        if (r0 > g) r0 = r0 - a;
        if (r - r0 == Q - 1) begin
          r1 = 0;
          r0 = r0 - 1;
        end else begin
          r1 = (r - r0) / a;
        end
      end
      if (r0 < 0) r0 = r0 + Q;
      da[k*R1_W +: R1_W]       = R1_W'(r1);
      db[k*COEFF_W +: COEFF_W] = COEFF_W'(r0);
    end
  endfunction

  function automatic logic [LANES*COEFF_W-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    pack4 = {COEFF_W'(l3), COEFF_W'(l2), COEFF_W'(l1), COEFF_W'(l0)};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Present one beat and hold it until the DUT takes it; returns just after the accepting edge.
  task automatic applyStimulus(input logic [LANES*COEFF_W-1:0] d, input logic [2:0] s, input logic m);
    bit taken;
    taken       = 1'b0;
    bus.di      = d;
    bus.sec_lvl = s;
    bus.mode    = m;
    bus.valid_i = 1'b1;
    for (int t = 0; t < 100 && !taken; t++) begin
      @(negedge clk);
      taken = bus.ready_i;
      @(posedge clk);
      #1;
    end
    if (!taken) failNow("accept_timeout");
  endtask

  task automatic idle(input int n);
    bus.valid_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected-value producer: every accepted beat is modelled and queued; reset discards in-flight beats.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else if (bus.valid_i && bus.ready_i) begin
      model(bus.di, bus.sec_lvl, bus.mode, e.doa, e.dob);
      e.t_in = cyc;
      e.lat  = lat_mode;
      sb.push_back(e);
    end
  end

  // Monitor: every output transfer must match the oldest outstanding beat.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.valid_o && bus.ready_o) begin
      if (sb.size() == 0) begin
        failNow("unexpected_output_beat");
      end else begin
        e = sb.pop_front();
        checkOutput("doa", 128'(bus.doa), 128'(e.doa));
        checkOutput("dob", 128'(bus.dob), 128'(e.dob));
        if (e.lat) checkOutput("latency", 128'(cyc - e.t_in), 128'(3));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0] s;
    cyc         = 0;
    checks      = 0;
    passes      = 0;
    lat_mode    = 1'b1;
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_o = 1'b1;
    bus.di      = '0;
    bus.sec_lvl = 3'b010;
    bus.mode    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready_i", 128'(bus.ready_i), 128'(1));
    checkOutput("reset_valid_o", 128'(bus.valid_o), 128'(0));
    checkOutput("reset_doa", 128'(bus.doa), 128'(0));
    checkOutput("reset_dob", 128'(bus.dob), 128'(0));
    @(posedge clk);
    #1;

    $display("[TB] directed Decompose / Power2Round beats");
    applyStimulus(pack4(2312250, 8022100, 300000, 8380416), 3'b010, 1'b0);
    idle(4);
    applyStimulus(pack4(2312250, 8022100, 0, 8380416), 3'b000, 1'b0);
    applyStimulus(pack4(8380417, 8380416, 8380417, 1), 3'b010, 1'b0);
    applyStimulus(pack4(8380417, 8380416, 523775, 261889), 3'b101, 1'b0);
    applyStimulus(pack4(2312250, 8191, 4096, 8380416), 3'b010, 1'b1);
    applyStimulus(pack4(4097, 8380417, 8192, 0), 3'b000, 1'b1);
    idle(5);

    $display("[TB] back-to-back random beats, config changing every beat");
    for (int i = 0; i < 40; i++) begin
      s = 3'($urandom_range(7, 0));
      if (s == 3'b010) s = 3'b111;
      if (i % 2 == 0) s = 3'b010;
      applyStimulus(pack4($urandom_range(2*Q-1, 0), $urandom_range(Q-1, 0),
                          $urandom_range(2*Q-1, 0), $urandom_range(Q-1, 0)),
                    s, 1'((i / 2) % 2) ^ 1'(i % 2));
    end
    idle(5);

    $display("[TB] downstream stall with a full pipeline");
    lat_mode = 1'b0;
    applyStimulus(pack4(111, 2222222, 7000000, 8380416), 3'b010, 1'b0);
    applyStimulus(pack4(333, 4444444, 6000000, 8191), 3'b001, 1'b1);
    applyStimulus(pack4(555, 5555555, 5000000, 95233), 3'b010, 1'b0);
    bus.ready_o = 1'b0;
    bus.di      = pack4(777, 1234567, 7654321, 4097);
    bus.sec_lvl = 3'b000;
    bus.mode    = 1'b0;
    bus.valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_valid_o", 128'(bus.valid_o), 128'(1));
      checkOutput("stall_ready_i", 128'(bus.ready_i), 128'(0));
      if (sb.size() != 0) begin
        checkOutput("stall_doa", 128'(bus.doa), 128'(sb[0].doa));
        checkOutput("stall_dob", 128'(bus.dob), 128'(sb[0].dob));
      end else begin
        failNow("stall_scoreboard_empty");
      end
    end
    @(posedge clk);
    #1 bus.ready_o = 1'b1;
    applyStimulus(pack4(777, 1234567, 7654321, 4097), 3'b000, 1'b0);
    idle(6);

    $display("[TB] reset with three beats in flight");
    lat_mode = 1'b1;
    applyStimulus(pack4(1, 2, 3, 4), 3'b010, 1'b0);
    applyStimulus(pack4(5000, 6000, 7000, 8000), 3'b000, 1'b1);
    applyStimulus(pack4(300000, 8022100, 2312250, 9), 3'b010, 1'b0);
    bus.valid_i = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_valid_o", 128'(bus.valid_o), 128'(0));
    checkOutput("post_reset_doa", 128'(bus.doa), 128'(0));
    checkOutput("post_reset_dob", 128'(bus.dob), 128'(0));
    @(posedge clk);
    #1;
    idle(4);
    applyStimulus(pack4(8022100, 300000, 8380416, 2312250), 3'b010, 1'b0);
    idle(2);

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/coeff_decomposer_lanes.md
Name: coeff_decomposer_lanes

Overview:
Multi-lane, fully pipelined successor to the single-lane coefficient decomposer for the Dilithium signing/verify datapath. Each accepted beat carries LANES coefficients mod q = 8380417. Every lane is split into a high part r1 and a low part r0 by one of two functions:
- Decompose, with gamma2 selected by sec_lvl.
- Power2Round, with d = 13.

sec_lvl and mode travel with the data, so they may change on any beat. The block sits between the NTT/poly-arith output stream and the hint/packing units, behind a valid/ready handshake with backpressure.

Parameters:
LANES, 4, coefficients processed per beat.
COEFF_W, 24, width of one input coefficient and one r0 output.
R1_W, 10, width of one r1 output. Must be at least 10 to hold the Power2Round maximum of 1023.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
sec_lvl  in  3  3'b010 selects gamma2 = (q-1)/88 = 95232; any other value selects gamma2 = (q-1)/32 = 261888.
mode  in  1  0 = Decompose, 1 = Power2Round.
valid_i  in  1  upstream beat valid.
ready_i  out  1  block can accept a beat this cycle.
di  in  LANES*COEFF_W  input coefficients; lane k is at bits [k*COEFF_W +: COEFF_W].
valid_o  out  1  output beat valid.
ready_o  in  1  downstream accepts the output beat.
doa  out  LANES*R1_W  r1 per lane, unsigned.
dob  out  LANES*COEFF_W  r0 per lane as a residue in [0,q-1]; a negative r0 is emitted as r0+q.

Behaviour:
- Transfers: an input transfer occurs when valid_i & ready_i. An output transfer occurs when valid_o & ready_o.
- Pipeline: 3 register stages (S1, S2, S3). S3 drives valid_o/doa/dob.
- Latency: a beat accepted at edge N appears at S3 after edge N+2, provided there is no stall.
- Throughput: 1 beat/cycle.
- Stall control: global enable en = !valid_o | ready_o, and ready_i = en (combinational).
  - When en=1, all stages advance. Each stage valid bit loads the previous stage's valid bit; the S1 valid bit loads valid_i.
  - When en=0, every stage holds. doa/dob/valid_o stay stable until the beat is taken.
- Bubbles are not collapsed. A bubble advances only with en.
- Per-beat config: sec_lvl and mode are captured at acceptance and piped alongside the data. Output of beat j uses only beat j's config.
- Input range: if di lane ≥ q, subtract q once. Inputs ≥ 2q are undefined.
- Decompose (a = 2*gamma2):
  - r0' = r mod a. If r0' > gamma2, then r0' -= a.
  - If r - r0' == q-1, then r1 = 0 and r0 = r0' - 1.
  - Otherwise r1 = (r - r0')/a and r0 = r0'.
  - Range of r1: 0..15 (gamma2 = 261888) or 0..43 (gamma2 = 95232). Upper doa bits are zero.
- Power2Round:
  - r0' = r mod 8192. If r0' > 4096, then r0' -= 8192.
  - r1 = (r - r0') >> 13, range 0..1023. r0 = r0'.
- Arithmetic: exact integer results are required. The implementation may use Barrett/reciprocal multiply, with constants sized so that no lane input 0..q-1 is ever off by one.
- Lanes: all lanes are independent and share the handshake. There is no lane masking.
- Reset values: all stage valid bits = 0; valid_o = 0; doa = 0; dob = 0. ready_i = 1 in the cycle after reset deasserts.
- Reset mid-operation: in-flight beats are discarded and not emitted. rst overrides en.
- Simultaneous input and output transfer in the same cycle with the pipeline full: legal; the pipeline shifts by one.

Test Plan:
1. Basic Decompose, gamma2 = 95232, ready_o = 1, lane 0 = 2312250 -> 3 cycles later doa = 12, dob = 26682. Lane 0 = 8022100 -> r1 = 42, r0 = 22612. Lane 0 = 300000 -> r1 = 2, r0 = 8299489.
2. Decompose, sec_lvl = 0 (gamma2 = 261888), 2312250 -> r1 = 4, r0 = 217146. 8022100 -> r1 = 15, r0 = 165460. 0 -> r1 = 0, r0 = 0.
3. Corner q-1 = 8380416 under both sec_lvl values -> r1 = 0, dob = 8380416. Input 8380417 (= q) -> r1 = 0, r0 = 0.
4. Power2Round, 2312250 -> r1 = 282, r0 = 2106. 8191 -> r1 = 1, r0 = 8380416. 4096 -> r1 = 0, r0 = 4096.
5. Back-to-back beats alternating sec_lvl and mode every cycle, with LANES = 4 and distinct lane values -> every output matches its own beat's config and lane order is preserved. Then hold ready_o = 0 for 5 cycles -> valid_o and data stable, ready_i = 0, no beat lost or duplicated once ready_o returns.
6. Assert rst for 1 cycle with 3 beats in flight -> valid_o = 0, doa = 0, dob = 0 next cycle, no stale beat emitted, and a new beat after reset returns correctly at latency 3.
